// File: rtl/turn_resolver_if.sv
// Turn-resolution bundle between the game FSM / projectile side (master) and turn_resolver (slave).
// proj_crit exists only when CVD_CRIT_DMG_EN is defined.
interface turn_resolver_if;
  logic       start_game;
  logic       dog_turn;
  logic       cat_turn;
  logic       throw_launch;
  logic       proj_landed;
  logic       proj_hit;
`ifdef CVD_CRIT_DMG_EN
  logic       proj_crit;
`endif
  logic [9:0] hp_local;
  logic [9:0] hp_remote;
  logic       turn_done_dog;
  logic       turn_done_cat;
  logic       busy;
  logic       timeout_flag;

  modport master (
`ifdef CVD_CRIT_DMG_EN
    output proj_crit,
`endif
    output start_game,
    output dog_turn,
    output cat_turn,
    output throw_launch,
    output proj_landed,
    output proj_hit,
    input  hp_local,
    input  hp_remote,
    input  turn_done_dog,
    input  turn_done_cat,
    input  busy,
    input  timeout_flag
  );

  modport slave (
`ifdef CVD_CRIT_DMG_EN
    input  proj_crit,
`endif
    input  start_game,
    input  dog_turn,
    input  cat_turn,
    input  throw_launch,
    input  proj_landed,
    input  proj_hit,
    output hp_local,
    output hp_remote,
    output turn_done_dog,
    output turn_done_cat,
    output busy,
    output timeout_flag
  );
endinterface

// File: rtl/turn_resolver.sv
// Owns both players' HP and resolves one throw per turn: launch, landing, damage, done strobe.
// Optional feature macro: CVD_CRIT_DMG_EN (critical hits subtract CRIT_DMG).
module turn_resolver #(
  parameter int unsigned HP_MAX       = 100,
  parameter int unsigned HIT_DMG      = 20,
  parameter int unsigned CRIT_DMG     = 35,
  parameter int unsigned TURN_TIMEOUT = 600000000
) (
  input logic            clk,
  input logic            rst_n,
  turn_resolver_if.slave ctrl_io
);

  localparam int unsigned CntW = (TURN_TIMEOUT > 2) ? $clog2(TURN_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TURN_TIMEOUT - 1);
  localparam logic [9:0] HpMax  = 10'(HP_MAX);
  localparam logic [9:0] HitDmg = 10'(HIT_DMG);

  if (HP_MAX > 1023) begin : g_bad_hp_max
    $error("HP_MAX must fit in 10 bits");
  end
  if (HIT_DMG > 1023 || CRIT_DMG > 1023) begin : g_bad_dmg
    $error("damage values must fit in 10 bits");
  end
  if (TURN_TIMEOUT < 2) begin : g_bad_timeout
    $error("TURN_TIMEOUT must be at least 2");
  end

  typedef enum logic [2:0] {
    StIdle,
    StWaitThrow,
    StInFlight,
    StApply,
    StDone,
    StWaitRelease
  } state_e;

  typedef enum logic {
    OwnDog,
    OwnCat
  } owner_e;

  state_e          state_q;
  owner_e          owner_q;
  logic [CntW-1:0] cnt_q;
  logic            hit_q;
  logic            timeout_q;
  logic            start_q;
  logic [9:0]      hp_local_q;
  logic [9:0]      hp_remote_q;
  logic            done_dog_q;
  logic            done_cat_q;
  logic            busy_q;
  logic            timeout_flag_q;
`ifdef CVD_CRIT_DMG_EN
  localparam logic [9:0] CritDmg = 10'(CRIT_DMG);
  logic            crit_q;
`endif

  logic            start_rise;
  logic            owner_turn;
  logic            other_turn;
  logic [9:0]      dmg;
  logic [9:0]      target_hp;
  logic [9:0]      target_hp_next;
  logic [CntW-1:0] cnt_inc;

  always_comb begin
    start_rise = ctrl_io.start_game & ~start_q;
    owner_turn = (owner_q == OwnDog) ? ctrl_io.dog_turn : ctrl_io.cat_turn;
    other_turn = (owner_q == OwnDog) ? ctrl_io.cat_turn : ctrl_io.dog_turn;
`ifdef CVD_CRIT_DMG_EN
    dmg = crit_q ? CritDmg : HitDmg;
`else
    dmg = HitDmg;
`endif
    // The attacker damages the opponent.
    target_hp      = (owner_q == OwnDog) ? hp_remote_q : hp_local_q;
    target_hp_next = (target_hp > dmg) ? (target_hp - dmg) : '0;
    cnt_inc        = cnt_q + CntW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      owner_q        <= OwnDog;
      cnt_q          <= '0;
      hit_q          <= 1'b0;
      timeout_q      <= 1'b0;
      start_q        <= 1'b0;
      hp_local_q     <= HpMax;
      hp_remote_q    <= HpMax;
      done_dog_q     <= 1'b0;
      done_cat_q     <= 1'b0;
      busy_q         <= 1'b0;
      timeout_flag_q <= 1'b0;
`ifdef CVD_CRIT_DMG_EN
      crit_q         <= 1'b0;
`endif
    end else begin
      start_q        <= ctrl_io.start_game;
      done_dog_q     <= 1'b0;
      done_cat_q     <= 1'b0;
      timeout_flag_q <= 1'b0;
      if (start_rise) begin
        // New game overrides whatever turn was in progress.
        state_q     <= StIdle;
        hp_local_q  <= HpMax;
        hp_remote_q <= HpMax;
        busy_q      <= 1'b0;
        timeout_q   <= 1'b0;
        hit_q       <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (ctrl_io.dog_turn ^ ctrl_io.cat_turn) begin
              state_q   <= StWaitThrow;
              owner_q   <= ctrl_io.dog_turn ? OwnDog : OwnCat;
              cnt_q     <= '0;
              timeout_q <= 1'b0;
              hit_q     <= 1'b0;
            end
          end
          StWaitThrow: begin
            if (!owner_turn) begin
              state_q <= StIdle;
            end else if (ctrl_io.throw_launch) begin
              state_q <= StInFlight;
              busy_q  <= 1'b1;
            end else if (cnt_inc == CntLast) begin
              state_q   <= StDone;
              timeout_q <= 1'b1;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          StInFlight: begin
            if (!owner_turn) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end else if (ctrl_io.proj_landed) begin
              state_q <= StApply;
              hit_q   <= ctrl_io.proj_hit;
`ifdef CVD_CRIT_DMG_EN
              crit_q  <= ctrl_io.proj_crit;
`endif
            end
          end
          StApply: begin
            busy_q <= 1'b0;
            if (!owner_turn) begin
              state_q <= StIdle;
            end else begin
              state_q <= StDone;
              if (hit_q) begin
                if (owner_q == OwnDog) hp_remote_q <= target_hp_next;
                else                   hp_local_q  <= target_hp_next;
              end
            end
          end
          StDone: begin
            state_q        <= StWaitRelease;
            done_dog_q     <= (owner_q == OwnDog);
            done_cat_q     <= (owner_q == OwnCat);
            timeout_flag_q <= timeout_q;
          end
          StWaitRelease: begin
            // Hold until the game FSM moves on so its check-win cycle cannot retrigger us.
            if (!owner_turn || other_turn) state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign ctrl_io.hp_local      = hp_local_q;
  assign ctrl_io.hp_remote     = hp_remote_q;
  assign ctrl_io.turn_done_dog = done_dog_q;
  assign ctrl_io.turn_done_cat = done_cat_q;
  assign ctrl_io.busy          = busy_q;
  assign ctrl_io.timeout_flag  = timeout_flag_q;

endmodule
